// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, next-PC selection and instruction field split.
// Bit 0 is the MSB on every [0:N] vector.
module fetch_cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic [31:0] g, p, c;
  logic [7:0]  gg, gp, gc;
  logic        term, acc_p;

  always_comb begin
    g = a & b;
    p = a ^ b;
    gg = '0;
    gp = '1;
    gc = '0;
    c = '0;
    term = 1'b0;
    acc_p = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        gg[i] = g[4*i+k] | (p[4*i+k] & gg[i]);
        gp[i] = gp[i] & p[4*i+k];
      end
    end
    // Group carries in flattened lookahead form; carry-in is zero.
    for (int i = 0; i < 7; i++) begin
      term = gg[i];
      acc_p = gp[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (acc_p & gg[j]);
        acc_p = acc_p & gp[j];
      end
      gc[i+1] = term;
    end
    for (int i = 0; i < 8; i++) begin
      c[4*i] = gc[i];
      for (int k = 1; k < 4; k++)
        c[4*i+k] = g[4*i+k-1] | (p[4*i+k-1] & c[4*i+k-1]);
    end
    sum = p ^ c;
  end
endmodule

module fetch_pc_unit #(
  parameter logic [31:0] INIT_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:31] instr,
  input  logic [0:1]  jump_type,
  input  logic        cond_src,
  input  logic [0:31] alu_out,
  input  logic [0:31] fpsr,
  input  logic [0:31] jump_reg,
  input  logic [0:31] iar,
  output logic [0:31] pc,
  output logic [0:31] pc_plus_8,
  output logic [0:31] next_pc,
  output logic        take_jump,
  output logic [0:5]  opcode,
  output logic [0:5]  func,
  output logic [0:4]  rs1,
  output logic [0:4]  rs2,
  output logic [0:4]  rd,
  output logic [0:15] imm
);
  logic [0:31] pc_plus_4, tgt16, tgt26, sext16, sext26, target;
  logic        uncond, is_branch, cond;
  logic        unused_bits;

  assign unused_bits = ^{alu_out[0:30], fpsr[0:30]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= INIT_ADDRESS;
    else        pc <= next_pc;
  end

  assign sext16 = {{16{instr[16]}}, instr[16:31]};
  assign sext26 = {{6{instr[6]}}, instr[6:31]};

  fetch_cla32 u_add4  (.a(pc),        .b(32'd4),  .sum(pc_plus_4));
  fetch_cla32 u_add8  (.a(pc_plus_4), .b(32'd4),  .sum(pc_plus_8));
  fetch_cla32 u_add16 (.a(pc_plus_4), .b(sext16), .sum(tgt16));
  fetch_cla32 u_add26 (.a(pc_plus_4), .b(sext26), .sum(tgt26));

  assign opcode = instr[0:5];
  assign rs1    = instr[6:10];
  assign rs2    = instr[11:15];
  assign rd     = instr[16:20];
  assign imm    = instr[16:31];
  assign func   = opcode[5] ? {1'b0, instr[27:31]} : instr[26:31];

  assign uncond = (opcode == 6'h02) || (opcode == 6'h03) ||
                  (opcode == 6'h12) || (opcode == 6'h13);
  assign is_branch = (opcode[0:2] == 3'b000) && opcode[3];
  assign cond      = cond_src ? alu_out[31] : fpsr[31];
  assign take_jump = uncond || (is_branch && cond);

  always_comb begin
    target = jump_reg;
    unique case (jump_type)
      2'b00: target = jump_reg;
      2'b01: target = tgt16;
      2'b10: target = tgt26;
      2'b11: target = iar;
      default: target = jump_reg;
    endcase
  end

  assign next_pc = take_jump ? target : pc_plus_4;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expected values queued at drive time,
// popped and asserted once the combinational outputs settle.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [0:31] instr, alu_out, fpsr, jump_reg, iar;
  logic [0:1]  jump_type;
  logic        cond_src;
  logic [0:31] pc, pc_plus_8, next_pc;
  logic        take_jump;
  logic [0:5]  opcode, func;
  logic [0:4]  rs1, rs2, rd;
  logic [0:15] imm;

  logic [31:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  fetch_pc_unit #(.INIT_ADDRESS(32'h0)) dut (
    .clk(clk), .reset(reset), .instr(instr), .jump_type(jump_type),
    .cond_src(cond_src), .alu_out(alu_out), .fpsr(fpsr),
    .jump_reg(jump_reg), .iar(iar), .pc(pc), .pc_plus_8(pc_plus_8),
    .next_pc(next_pc), .take_jump(take_jump), .opcode(opcode),
    .func(func), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input logic [31:0] a);
    instr = 32'h48000000;
    jump_type = 2'b00;
    jump_reg = a;
    step();
  endtask

  initial begin
    reset = 1'b0; instr = '0; jump_type = 2'b00; cond_src = 1'b0;
    alu_out = '0; fpsr = '0; jump_reg = '0; iar = '0;
    #2;
    exp_q.push_back(32'h0); chk("reset_pc", pc);
    exp_q.push_back(32'h8); chk("reset_pc8", pc_plus_8);

    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'h4); step(); chk("seq_4", pc);
    exp_q.push_back(32'h8); step(); chk("seq_8", pc);
    exp_q.push_back(32'hC); step(); chk("seq_12", pc);

    goto(32'h40);
    exp_q.push_back(32'h40); chk("goto_40", pc);
    instr = '0;
    reset = 1'b0;
    #1;
    exp_q.push_back(32'h0); chk("async_rst", pc);
    #1;
    reset = 1'b1;
    exp_q.push_back(32'h4); step(); chk("after_rst", pc);

    goto(32'h100);
    instr = 32'h0BFFFFF8; jump_type = 2'b10;
    exp_q.push_back(32'h1); exp_q.push_back(32'hFC);
    exp_q.push_back(32'h108);
    #1;
    chk("j_take", {31'b0, take_jump});
    chk("j_next", next_pc);
    chk("j_pc8", pc_plus_8);
    exp_q.push_back(32'hFC); step(); chk("j_load", pc);

    goto(32'h20);
    instr = 32'h10000010; jump_type = 2'b01; cond_src = 1'b1;
    alu_out = 32'h1;
    exp_q.push_back(32'h34); exp_q.push_back(32'h1);
    #1; chk("br_alu1", next_pc); chk("br_alu1_t", {31'b0, take_jump});
    alu_out = 32'h0;
    exp_q.push_back(32'h24); exp_q.push_back(32'h0);
    #1; chk("br_alu0", next_pc); chk("br_alu0_t", {31'b0, take_jump});
    cond_src = 1'b0; alu_out = 32'h1; fpsr = 32'h0;
    exp_q.push_back(32'h24);
    #1; chk("br_fp0", next_pc);
    fpsr = 32'h1;
    exp_q.push_back(32'h34);
    #1; chk("br_fp1", next_pc);
    instr = 32'h1C00FFF0;
    exp_q.push_back(32'h14);
    #1; chk("br_neg", next_pc);

    instr = 32'h48000000; jump_type = 2'b00; jump_reg = 32'h1234;
    exp_q.push_back(32'h1234);
    #1; chk("jr", next_pc);
    instr = 32'h0C000000; jump_type = 2'b11; iar = 32'h80;
    exp_q.push_back(32'h80);
    #1; chk("rfe_iar", next_pc);
    instr = 32'h04000000;
    exp_q.push_back(32'h24); exp_q.push_back(32'h0);
    #1; chk("op01_next", next_pc); chk("op01_t", {31'b0, take_jump});

    instr = 32'h04220005;
    exp_q.push_back(32'h01); exp_q.push_back(32'h05);
    exp_q.push_back(32'h01); exp_q.push_back(32'h02);
    exp_q.push_back(32'h00); exp_q.push_back(32'h0005);
    #1;
    chk("opcode", {26'b0, opcode});
    chk("func_a", {26'b0, func});
    chk("rs1", {27'b0, rs1});
    chk("rs2", {27'b0, rs2});
    chk("rd", {27'b0, rd});
    chk("imm", {16'b0, imm});
    instr = 32'h08000025;
    exp_q.push_back(32'h25);
    #1; chk("func_op5_0", {26'b0, func});
    instr = 32'h0400003F;
    exp_q.push_back(32'h1F);
    #1; chk("func_op5_1", {26'b0, func});

    goto(32'hFFFFFFFC);
    instr = '0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    #1; chk("wrap_next", next_pc); chk("wrap_pc8", pc_plus_8);
    exp_q.push_back(32'h0); step(); chk("wrap_load", pc);

    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0",
             exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
